// File: rtl/uart_rx_fifo_if.sv
// Byte stream handshake between the UART receiver FIFO and its consumer.
// The master drives the data and valid signals, and the slave drives ready.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small fall-through RX FIFO and a clear_req pop echo.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ser_rx,
  uart_rx_fifo_if.master              rx,
  output logic                        clear_req,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t      state;
  logic [1:0]  sync_reg;
  logic        rxs;
  logic        rxs_d;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  logic            stop_sample;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic            not_empty;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      mem [FIFO_DEPTH];

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], ser_rx};
    end
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rxs_d     <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rxs_d     <= rxs;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (!rxs) begin
            state   <= DATA;
            cnt     <= BIT_LOAD;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            shift <= {rxs, shift[7:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            // Even parity: data bits plus parity bit must hold an even number of ones.
            par_bad <= ^{shift, rxs};
            cnt     <= BIT_LOAD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            // Returning to IDLE right at the stop centre leaves half a bit to catch the next start edge.
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy     = (state != IDLE);
  assign stop_sample = (state == STOP) && (cnt == 16'd0);
`ifdef UART_RX_PARITY_EN
  assign push_req    = stop_sample && rxs && !par_bad;
`else
  assign push_req    = stop_sample && rxs;
`endif

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FULL_COUNT);
  assign not_empty = (count != '0);
  assign pop       = not_empty && rx.rx_ready;
  // A pop on a full FIFO frees the slot in the same cycle, so the push still lands.
  assign push_ok   = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      clear_req <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      clear_req <= pop;
      overrun   <= push_req && full && !pop;
    end
  end

  assign fifo_count  = count;
  assign rx.rx_valid = not_empty;
  assign rx.rx_data  = not_empty ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: normal traffic, overflow, glitch, break and reset mid-frame.
// Also covers the parity frame when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_rx = 1'b1;
  logic       clear_req, frame_err, overrun, rx_busy;
  logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo_if rxif ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_rx     (ser_rx),
    .rx         (rxif),
    .clear_req  (clear_req),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int clr_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, max_cnt = 0;
  logic [7:0] popq[$];

  // Monitor: pulse counters and popped bytes, sampled on the falling edge.
  always @(negedge clk) begin
    if (clear_req) clr_cnt++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (rxif.rx_valid && rxif.rx_ready) popq.push_back(rxif.rx_data);
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    ser_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par_bit);
`else
    if (par_bit === 1'bx) ser_rx = 1'b1;
`endif
    bit_time(stop_bit);
    ser_rx = 1'b1;
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (popq.size() < target && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(tag, popq.size(), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq1 [4];
    int base, fe0, ov0, clr0, pe0;
    seq1[0] = 8'h3D; seq1[1] = 8'h0F; seq1[2] = 8'h12; seq1[3] = 8'h37;
    rxif.rx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", rxif.rx_valid, 0);
    check("rst_data", rxif.rx_data, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_flags", {clear_req, frame_err, overrun}, 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Paced traffic with rx_ready held high
    for (int i = 0; i < 4; i++) begin
      send_frame(seq1[i], 1'b1, ^seq1[i]);
      wait_pops(i + 1, "seq1_pop");
      check("seq1_data", popq[i], seq1[i]);
      check("seq1_clr", clr_cnt, i + 1);
      repeat (CPB) @(negedge clk);
    end
    check("seq1_fe", fe_cnt, 0);
    check("seq1_ov", ov_cnt, 0);
    check("seq1_max", max_cnt, 1);

    // Overflow with rx_ready low
    rxif.rx_ready = 1'b0;
    base = popq.size(); ov0 = ov_cnt; clr0 = clr_cnt;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, ^(8'(k)));
    repeat (4) @(negedge clk);
    check("ovf_count4", fifo_count, 4);
    check("ovf_none_yet", ov_cnt - ov0, 0);
    send_frame(8'h05, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ovf_once", ov_cnt - ov0, 1);
    check("ovf_count", fifo_count, 4);
    check("ovf_head", rxif.rx_data, 8'h01);
    rxif.rx_ready = 1'b1;
    wait_pops(base + 4, "ovf_drain");
    for (int k = 0; k < 4; k++) check("ovf_order", popq[base + k], k + 1);
    repeat (4) @(negedge clk);
    check("ovf_empty", fifo_count, 0);
    check("ovf_clr", clr_cnt - clr0, 4);

    // Short low glitch is rejected at the start-bit centre
    base = popq.size(); fe0 = fe_cnt;
    ser_rx = 1'b0;
    repeat (5) @(negedge clk);
    ser_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", rx_busy, 1);
    repeat (20) @(negedge clk);
    check("glitch_idle", rx_busy, 0);
    check("glitch_valid", rxif.rx_valid, 0);
    check("glitch_nopush", popq.size(), base);
    check("glitch_fe", fe_cnt - fe0, 0);

    // Framing error followed by a held-low line
    send_frame(8'hA5, 1'b0, ^(8'hA5));
    ser_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("brk_busy", rx_busy, 1);
    check("brk_fe", fe_cnt - fe0, 1);
    ser_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("brk_idle", rx_busy, 0);
    check("brk_nopush", popq.size(), base);
    send_frame(8'h5A, 1'b1, ^(8'h5A));
    wait_pops(base + 1, "brk_pop");
    check("brk_data", popq[base], 8'h5A);
    repeat (20) @(negedge clk);
    check("brk_single", popq.size(), base + 1);
    check("brk_fe_once", fe_cnt - fe0, 1);

    // Reset in the middle of bit 4 of 0xC3
    rxif.rx_ready = 1'b0;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(((8'hC3 >> i) & 8'h01) != 0);
    ser_rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    check("mid_busy", rx_busy, 1);
    rst_n = 1'b0;
    ser_rx = 1'b1;
    @(negedge clk);
    check("rst2_outs", {rxif.rx_valid, rx_busy, clear_req, frame_err, overrun}, 0);
    check("rst2_data", rxif.rx_data, 8'h00);
    @(negedge clk);
    check("rst2_count", fifo_count, 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("rst2_empty", fifo_count, 0);
    send_frame(8'h81, 1'b1, ^(8'h81));
    repeat (4) @(negedge clk);
    check("rst2_one", fifo_count, 1);
    check("rst2_data81", rxif.rx_data, 8'h81);
    base = popq.size();
    rxif.rx_ready = 1'b1;
    wait_pops(base + 1, "rst2_pop");
    check("rst2_popped", popq[base], 8'h81);

`ifdef UART_RX_PARITY_EN
    // Bad parity on 0x07, then the correct parity bit (1)
    repeat (CPB) @(negedge clk);
    base = popq.size(); pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    check("par_err", pe_cnt - pe0, 1);
    check("par_nopush", popq.size(), base);
    check("par_fe", fe_cnt - fe0, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_pops(base + 1, "par_pop");
    check("par_data", popq[base], 8'h07);
    check("par_err_once", pe_cnt - pe0, 1);
`else
    pe0 = pe_cnt;
    check("no_parity_err", pe0, 0);
`endif

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
